// File: rtl/fxu_pipe.sv
// Fixed-point execution unit: MOV/ADD/SUB/JEQ/JLT with an in-order result queue drained by the CDB.
// Optional iterative multiplier (opcode 10) is enabled by defining FXU_MUL_EN.
module fxu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [TAG_W-1:0] rs_num,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  output logic             busy,
  output logic             valid_out,
  output logic [TAG_W-1:0] rs_num_out,
  output logic [3:0]       op_out,
  output logic [WIDTH-1:0] res_out,
  input  logic             cdb_ack
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_JEQ = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_JLT = 4'd9;

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [3:0]       op_mem  [DEPTH];
  logic [WIDTH-1:0] res_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic             mul_active;
  logic             accept;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] push_tag;
  logic [3:0]       push_op;
  logic [WIDTH-1:0] push_res;
  logic [WIDTH-1:0] alu_res;

  assign busy   = (count_q == FULL_CNT) || mul_active;
  assign accept = valid && !busy;
  assign pop    = (count_q != '0) && cdb_ack;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_MOV:  alu_res = val0;
      OP_ADD:  alu_res = val0 + val1;
      OP_SUB:  alu_res = val0 - val1;
      OP_JEQ:  alu_res = {{(WIDTH-1){1'b0}}, (val0 == val1)};
      OP_JLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(val0) < $signed(val1))};
      default: alu_res = '0;
    endcase
  end

`ifdef FXU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;
  logic             is_mul;

  assign is_mul     = (op == OP_MUL);
  assign mul_active = (state_q != MUL_IDLE);

  // Only the low WIDTH bits of the product are kept, so the shifted multiplicand can drop its MSBs.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    mtag_d   = mtag_q;
    case (state_q)
      MUL_IDLE: begin
        if (accept && is_mul) begin
          state_d  = MUL_RUN;
          mcand_d  = val0;
          mplier_d = val1;
          acc_d    = '0;
          iter_d   = '0;
          mtag_d   = rs_num;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + CW'(1);
        if (iter_q == CW'(WIDTH-1)) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      mtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      mtag_q   <= mtag_d;
    end
  end

  // DONE and a fresh accept never coincide: busy is held high through the DONE edge.
  always_comb begin
    push     = accept && !is_mul;
    push_tag = rs_num;
    push_op  = op;
    push_res = alu_res;
    if (state_q == MUL_DONE) begin
      push     = 1'b1;
      push_tag = mtag_q;
      push_op  = OP_MUL;
      push_res = acc_q;
    end
  end
`else
  assign mul_active = 1'b0;
  assign push       = accept;
  assign push_tag   = rs_num;
  assign push_op    = op;
  assign push_res   = alu_res;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= push_tag;
      op_mem[wr_ptr_q]  <= push_op;
      res_mem[wr_ptr_q] <= push_res;
    end
  end

  assign valid_out  = (count_q != '0);
  assign rs_num_out = valid_out ? tag_mem[rd_ptr_q] : '0;
  assign op_out     = valid_out ? op_mem[rd_ptr_q]  : '0;
  assign res_out    = valid_out ? res_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fxu_pipe.sv
// Directed self-checking bench for fxu_pipe (default parameters); MUL expectations follow FXU_MUL_EN.
module tb_fxu_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [5:0]  rs_num;
  logic [3:0]  op;
  logic [15:0] val0;
  logic [15:0] val1;
  logic        busy;
  logic        valid_out;
  logic [5:0]  rs_num_out;
  logic [3:0]  op_out;
  logic [15:0] res_out;
  logic        cdb_ack;

  int checks = 0;
  int errors = 0;

  fxu_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .rs_num     (rs_num),
    .op         (op),
    .val0       (val0),
    .val1       (val1),
    .busy       (busy),
    .valid_out  (valid_out),
    .rs_num_out (rs_num_out),
    .op_out     (op_out),
    .res_out    (res_out),
    .cdb_ack    (cdb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] head_vec();
    return {valid_out, rs_num_out, op_out, res_out};
  endfunction

  function automatic logic [26:0] mk(input logic v, input logic [5:0] t, input logic [3:0] o,
                                     input logic [15:0] r);
    return {v, t, o, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] t, input logic [3:0] o,
                       input logic [15:0] a, input logic [15:0] b);
    valid  = v;
    rs_num = t;
    op     = o;
    val0   = a;
    val1   = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cdb_ack = 1'b0;
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL reset_head: got %h expected %h", head_vec(), 27'd0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_add();
    logic [26:0] exp;
    cdb_ack = 1'b1;
    drive(1'b1, 6'd5, 4'd1, 16'h0003, 16'h0004);
    tick();
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    exp = mk(1'b1, 6'd5, 4'd1, 16'h0007);
    checks++;
    if (head_vec() !== exp) begin
      errors++;
      $display("FAIL add_head: got %h expected %h", head_vec(), exp);
    end
    tick();
    checks++;
    if (head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL add_drained: got %h expected %h", head_vec(), 27'd0);
    end
    $display("test_add: ADD tag5 3+4 retired");
  endtask

  task automatic test_wrap();
    logic [26:0] exp;
    cdb_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i), 4'd0, 16'h0100 + 16'(i), 16'h0);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL wrap_fill_busy%0d: got %b expected 0", i, busy);
      end
      tick();
    end
    drive(1'b1, 6'd5, 4'd0, 16'h0105, 16'h0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full_busy: got %b expected 1", busy);
    end
    tick();
    exp = mk(1'b1, 6'd1, 4'd0, 16'h0101);
    checks++;
    if (head_vec() !== exp || busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_reject: head %h busy %b expected %h busy 1", head_vec(), busy, exp);
    end
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    cdb_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = mk(1'b1, 6'(i), 4'd0, 16'h0100 + 16'(i));
      checks++;
      if (head_vec() !== exp) begin
        errors++;
        $display("FAIL wrap_pop%0d: got %h expected %h", i, head_vec(), exp);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL wrap_pop_busy%0d: got %b expected 0", i, busy);
      end
      $display("wrap: popped tag %0d", i);
    end
    checks++;
    if (head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL wrap_empty: got %h expected 0", head_vec());
    end
    cdb_ack = 1'b0;
    drive(1'b1, 6'd5, 4'd0, 16'h0105, 16'h0);
    tick();
    exp = mk(1'b1, 6'd5, 4'd0, 16'h0105);
    checks++;
    if (head_vec() !== exp) begin
      errors++;
      $display("FAIL wrap_retry: got %h expected %h", head_vec(), exp);
    end
    cdb_ack = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      drive(1'b1, 6'(i), 4'd0, 16'h0100 + 16'(i), 16'h0);
      tick();
      exp = mk(1'b1, 6'(i), 4'd0, 16'h0100 + 16'(i));
      checks++;
      if (head_vec() !== exp) begin
        errors++;
        $display("FAIL wrap_pushpop%0d: got %h expected %h", i, head_vec(), exp);
      end
    end
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    tick();
    checks++;
    if (head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL wrap_final_empty: got %h expected 0", head_vec());
    end
  endtask

  task automatic test_arith();
    logic [3:0]  t_op  [8] = '{4'd1, 4'd8, 4'd9, 4'd6, 4'd15, 4'd6, 4'd9, 4'd0};
    logic [15:0] t_a   [8] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h1234, 16'h5555, 16'h0001, 16'h0001, 16'hBEEF};
    logic [15:0] t_b   [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'h0002, 16'h8000, 16'h1111};
    logic [15:0] t_exp [8] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF};
    logic [26:0] exp;
    cdb_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 6'(20 + k), t_op[k], t_a[k], t_b[k]);
      tick();
      exp = mk(1'b1, 6'(20 + k), t_op[k], t_exp[k]);
      checks++;
      if (head_vec() !== exp) begin
        errors++;
        $display("FAIL arith%0d op%0d %h,%h: got %h expected %h", k, t_op[k], t_a[k], t_b[k], head_vec(), exp);
      end
      $display("arith: op %0d %h %h -> %h", t_op[k], t_a[k], t_b[k], res_out);
    end
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [26:0] exp;
    cdb_ack = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      drive(1'b1, 6'(i), 4'd0, 16'(i), 16'h0);
      tick();
    end
    cdb_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 6'(13 + k), 4'd0, 16'(13 + k), 16'h0);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy%0d: got %b expected 0", k, busy);
      end
      tick();
      exp = mk(1'b1, 6'(11 + k), 4'd0, 16'(11 + k));
      checks++;
      if (head_vec() !== exp) begin
        errors++;
        $display("FAIL b2b_head%0d: got %h expected %h", k, head_vec(), exp);
      end
    end
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    for (int j = 0; j < 3; j++) begin
      exp = mk(1'b1, 6'(20 + j), 4'd0, 16'(20 + j));
      checks++;
      if (head_vec() !== exp) begin
        errors++;
        $display("FAIL b2b_drain%0d: got %h expected %h", j, head_vec(), exp);
      end
      tick();
    end
    checks++;
    if (head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL b2b_empty: got %h expected 0", head_vec());
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_mul();
    logic [26:0] exp;
    cdb_ack = 1'b1;
    drive(1'b1, 6'd20, 4'd1, 16'h0001, 16'h0002);
    tick();
    exp = mk(1'b1, 6'd20, 4'd1, 16'h0003);
    checks++;
    if (head_vec() !== exp) begin
      errors++;
      $display("FAIL mul_pre_add: got %h expected %h", head_vec(), exp);
    end
    drive(1'b1, 6'd21, 4'd10, 16'h0012, 16'h0034);
    tick();
`ifdef FXU_MUL_EN
    checks++;
    if (busy !== 1'b1 || head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL mul_start: busy %b head %h expected busy 1 head 0", busy, head_vec());
    end
    drive(1'b1, 6'd30, 4'd1, 16'h0005, 16'h0006);
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL mul_run%0d: busy %b valid_out %b expected 1 0", e, busy, valid_out);
      end
    end
    tick();
    exp = mk(1'b1, 6'd21, 4'd10, 16'h03A8);
    checks++;
    if (head_vec() !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: head %h busy %b expected %h busy 0", head_vec(), busy, exp);
    end
`else
    exp = mk(1'b1, 6'd21, 4'd10, 16'h0000);
    checks++;
    if (head_vec() !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_unknown_op: head %h busy %b expected %h busy 0", head_vec(), busy, exp);
    end
    drive(1'b1, 6'd30, 4'd1, 16'h0005, 16'h0006);
`endif
    tick();
    exp = mk(1'b1, 6'd30, 4'd1, 16'h000B);
    checks++;
    if (head_vec() !== exp) begin
      errors++;
      $display("FAIL mul_follow_add: got %h expected %h", head_vec(), exp);
    end
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    tick();
    checks++;
    if (head_vec() !== 27'd0) begin
      errors++;
      $display("FAIL mul_empty: got %h expected 0", head_vec());
    end
    $display("test_mul: 0x12 x 0x34 tag21 done");
  endtask

  task automatic test_reset_mid();
    logic [26:0] exp;
    cdb_ack = 1'b0;
    drive(1'b1, 6'd40, 4'd0, 16'h0040, 16'h0);
    tick();
    drive(1'b1, 6'd41, 4'd0, 16'h0041, 16'h0);
    tick();
    drive(1'b1, 6'd42, 4'd10, 16'h0003, 16'h0003);
    tick();
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    repeat (4) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (head_vec() !== 27'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_immediate: head %h busy %b expected 0 0", head_vec(), busy);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (head_vec() !== 27'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale%0d: head %h busy %b expected 0 0", c, head_vec(), busy);
      end
    end
    drive(1'b1, 6'd1, 4'd1, 16'h0010, 16'h0020);
    tick();
    drive(1'b0, 6'd0, 4'd0, 16'h0, 16'h0);
    exp = mk(1'b1, 6'd1, 4'd1, 16'h0030);
    checks++;
    if (head_vec() !== exp) begin
      errors++;
      $display("FAIL rstmid_recover: got %h expected %h", head_vec(), exp);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_arith();
    test_back_to_back();
    test_mul();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
